// File: rtl/loader_pkg.sv
// Shared types and helpers for the cartridge ROM loader: FSM states, word geometry
// and the size-to-address-mask reduction used by the console read path.
package loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ACK,
      ST_WRITE,
      ST_RECOVER,
      ST_HOLD,
      ST_RUN
   } state_t;

   function automatic int BYTES_PER_WORD(input int host_w);
      return host_w / 8;
   endfunction

   // Smearing (size-1) rightwards yields the next power of two minus one.
   // A zero size smears to all ones and is then saturated like any oversize ROM.
   function automatic logic [31:0] size_to_mask(input logic [31:0] size, input int width);
      logic [31:0] m;
      logic [31:0] ones;
      m = size - 32'd1;
      for (int s = 1; s < 32; s = s * 2)
         m = m | (m >> s);
      ones = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
      return m & ones;
   endfunction

endpackage

// File: rtl/loader_addr_map.sv
// Console-side view of the SRAM: masks cartridge addresses to the loaded ROM size
// while running, otherwise passes the loader address through; gates read data.
module loader_addr_map
   import loader_pkg::*;
#(
   parameter int ADDR_W    = 19,
   parameter int VP_ADDR_W = 13,
   parameter int SIZE_W    = 16
) (
   input  logic                 run,
   input  logic [SIZE_W-1:0]    size_q,
   input  logic [VP_ADDR_W-1:0] vp_addr,
   input  logic                 vp_en_n,
   input  logic [ADDR_W-1:0]    load_addr,
   input  logic [7:0]           sram_rdata,
   output logic [ADDR_W-1:0]    sram_addr,
   output logic [7:0]           vp_data
);

   logic [31:0] mask_full;

   assign mask_full = size_to_mask(32'(size_q), VP_ADDR_W);

   always_comb begin
      sram_addr = load_addr;
      if (run)
         sram_addr = ADDR_W'(32'(vp_addr) & mask_full);
   end

   assign vp_data = (run && !vp_en_n) ? sram_rdata : 8'hFF;

endmodule

// File: rtl/cart_rom_loader.sv
// Boot-word loader: 4-phase host handshake, MSB-first byte unpacking into SRAM,
// reset hold, then cartridge read mapping. Define LOADER_CHECKSUM_EN for the byte sum.
module cart_rom_loader
   import loader_pkg::*;
#(
   parameter int HOST_W    = 32,
   parameter int ADDR_W    = 19,
   parameter int VP_ADDR_W = 13,
   parameter int SIZE_W    = 16,
   parameter int WAIT_CYC  = 1,
   parameter int RST_HOLD  = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 host_bootdata_reset,
   input  logic [HOST_W-1:0]    host_bootdata,
   input  logic                 host_bootdata_req,
   output logic                 host_bootdata_ack,
   input  logic [SIZE_W-1:0]    host_bootdata_size,
   output logic [ADDR_W-1:0]    sram_addr,
   inout  logic [7:0]           sram_data,
   output logic                 sram_we_n,
   input  logic [VP_ADDR_W-1:0] vp_addr,
   input  logic                 vp_en_n,
   output logic [7:0]           vp_data,
   output logic                 vp_rst_n,
   output logic                 loader_done,
   output logic [SIZE_W-1:0]    bytes_loaded,
   output logic [15:0]          checksum
);

   localparam int BPW   = BYTES_PER_WORD(HOST_W);
   localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

   state_t              state, state_next;
   logic [HOST_W-1:0]   word_q;
   logic [IDX_W-1:0]    idx;
   logic                discard;
   logic                size_valid;
   logic [SIZE_W-1:0]   size_q;
   logic [SIZE_W-1:0]   bytes_inc;
   logic [3:0]          wait_cnt;
   logic [7:0]          hold_cnt;
   logic                run_ack;
   logic [7:0]          cur_byte;
   logic                wait_last, hold_last, byte_last, load_end, zero_done;
   logic                drive, run;
   logic [ADDR_W-1:0]   load_addr;

   always_comb begin
      cur_byte = 8'h00;
      for (int b = 0; b < BPW; b++)
         if (idx == IDX_W'(BPW - 1 - b))
            cur_byte = word_q[8*b +: 8];
   end

   assign wait_last = (wait_cnt == 4'(WAIT_CYC - 1));
   assign hold_last = (hold_cnt == 8'(RST_HOLD - 1));
   assign byte_last = (idx == IDX_W'(BPW - 1));
   assign bytes_inc = (bytes_loaded == '1) ? bytes_loaded : bytes_loaded + SIZE_W'(1);
   assign load_end  = (bytes_inc == size_q);
   // An empty ROM completes as soon as its size is known, without any writes.
   assign zero_done = size_valid && (size_q == '0) && !loader_done;
   assign load_addr = ADDR_W'(bytes_loaded);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= ST_IDLE;
      else if (host_bootdata_reset)
         state <= ST_IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:
            if (zero_done)
               state_next = ST_HOLD;
            else if (host_bootdata_req)
               state_next = ST_ACK;
         ST_ACK:
            if (!host_bootdata_req)
               state_next = (discard || size_q == '0) ? ST_IDLE : ST_WRITE;
         ST_WRITE:
            state_next = ST_RECOVER;
         ST_RECOVER:
            if (wait_last) begin
               if (load_end)
                  state_next = ST_HOLD;
               else if (byte_last)
                  state_next = ST_IDLE;
               else
                  state_next = ST_WRITE;
            end
         ST_HOLD:
            if (hold_last)
               state_next = ST_RUN;
         ST_RUN:
            state_next = ST_RUN;
         default:
            state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      sram_we_n         = 1'b1;
      drive             = 1'b0;
      run               = 1'b0;
      vp_rst_n          = 1'b0;
      host_bootdata_ack = 1'b0;
      case (state)
         ST_ACK:   host_bootdata_ack = 1'b1;
         ST_WRITE: begin
            sram_we_n = 1'b0;
            drive     = 1'b1;
         end
         ST_RUN: begin
            run               = 1'b1;
            vp_rst_n          = 1'b1;
            host_bootdata_ack = run_ack;
         end
         default: ;
      endcase
   end

   // Datapath registers; a synchronous restart clears exactly what reset clears.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         word_q       <= '0;
         idx          <= '0;
         discard      <= 1'b0;
         size_valid   <= 1'b0;
         size_q       <= '0;
         bytes_loaded <= '0;
         loader_done  <= 1'b0;
         wait_cnt     <= '0;
         hold_cnt     <= '0;
         run_ack      <= 1'b0;
      end else if (host_bootdata_reset) begin
         word_q       <= '0;
         idx          <= '0;
         discard      <= 1'b0;
         size_valid   <= 1'b0;
         size_q       <= '0;
         bytes_loaded <= '0;
         loader_done  <= 1'b0;
         wait_cnt     <= '0;
         hold_cnt     <= '0;
         run_ack      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE:
               if (zero_done) begin
                  loader_done <= 1'b1;
                  hold_cnt    <= '0;
               end else if (host_bootdata_req) begin
                  discard <= loader_done;
                  if (!loader_done) begin
                     word_q <= host_bootdata;
                     if (!size_valid) begin
                        size_q     <= host_bootdata_size;
                        size_valid <= 1'b1;
                     end
                  end
               end
            ST_ACK:   idx <= '0;
            ST_WRITE: wait_cnt <= '0;
            ST_RECOVER:
               if (!wait_last)
                  wait_cnt <= wait_cnt + 4'd1;
               else begin
                  bytes_loaded <= bytes_inc;
                  if (load_end) begin
                     loader_done <= 1'b1;
                     hold_cnt    <= '0;
                  end else if (!byte_last)
                     idx <= idx + IDX_W'(1);
               end
            ST_HOLD:  hold_cnt <= hold_cnt + 8'd1;
            ST_RUN:   run_ack <= host_bootdata_req;
            default: ;
         endcase
      end
   end

`ifdef LOADER_CHECKSUM_EN
   logic [15:0] checksum_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         checksum_q <= '0;
      else if (host_bootdata_reset)
         checksum_q <= '0;
      else if (state == ST_RECOVER && wait_last)
         checksum_q <= checksum_q + 16'(cur_byte);
   end

   assign checksum = checksum_q;
`else
   assign checksum = 16'h0000;
`endif

   assign sram_data = drive ? cur_byte : 8'hZZ;

   loader_addr_map #(
      .ADDR_W    (ADDR_W),
      .VP_ADDR_W (VP_ADDR_W),
      .SIZE_W    (SIZE_W)
   ) u_addr_map (
      .run        (run),
      .size_q     (size_q),
      .vp_addr    (vp_addr),
      .vp_en_n    (vp_en_n),
      .load_addr  (load_addr),
      .sram_rdata (sram_data),
      .sram_addr  (sram_addr),
      .vp_data    (vp_data)
   );

endmodule

// File: tb/tb_cart_rom_loader.sv
// Scoreboard bench for cart_rom_loader: stimulus queues expected SRAM writes, a monitor
// pops them on every write cycle; directed checks cover handshake, timing and mapping.
module tb_cart_rom_loader;

   localparam int HOST_W    = 32;
   localparam int ADDR_W    = 19;
   localparam int VP_ADDR_W = 13;
   localparam int SIZE_W    = 16;
   localparam int WAIT_CYC  = 1;
   localparam int RST_HOLD  = 8;

`ifdef LOADER_CHECKSUM_EN
   localparam logic [15:0] EXP_SUM = 16'h01FF;
`else
   localparam logic [15:0] EXP_SUM = 16'h0000;
`endif

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 host_bootdata_reset;
   logic [HOST_W-1:0]    host_bootdata;
   logic                 host_bootdata_req;
   logic                 host_bootdata_ack;
   logic [SIZE_W-1:0]    host_bootdata_size;
   logic [ADDR_W-1:0]    sram_addr;
   wire  [7:0]           sram_data;
   logic                 sram_we_n;
   logic [VP_ADDR_W-1:0] vp_addr;
   logic                 vp_en_n;
   logic [7:0]           vp_data;
   logic                 vp_rst_n;
   logic                 loader_done;
   logic [SIZE_W-1:0]    bytes_loaded;
   logic [15:0]          checksum;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [7:0]        data;
   } wr_t;

   wr_t         exp_q[$];
   wr_t         mon_e;
   logic [7:0]  mem [0:(1<<ADDR_W)-1];
   int          vectors = 0;
   int          miscompares = 0;
   int          n;
   logic [31:0] big_word;
   logic [7:0]  pat;

   always #5 clk = ~clk;

   // SRAM read side only drives once the console is out of reset.
   assign sram_data = (sram_we_n && vp_rst_n) ? mem[sram_addr] : 8'hzz;

   cart_rom_loader #(
      .HOST_W    (HOST_W),
      .ADDR_W    (ADDR_W),
      .VP_ADDR_W (VP_ADDR_W),
      .SIZE_W    (SIZE_W),
      .WAIT_CYC  (WAIT_CYC),
      .RST_HOLD  (RST_HOLD)
   ) dut (
      .clk                 (clk),
      .reset               (reset),
      .host_bootdata_reset (host_bootdata_reset),
      .host_bootdata       (host_bootdata),
      .host_bootdata_req   (host_bootdata_req),
      .host_bootdata_ack   (host_bootdata_ack),
      .host_bootdata_size  (host_bootdata_size),
      .sram_addr           (sram_addr),
      .sram_data           (sram_data),
      .sram_we_n           (sram_we_n),
      .vp_addr             (vp_addr),
      .vp_en_n             (vp_en_n),
      .vp_data             (vp_data),
      .vp_rst_n            (vp_rst_n),
      .loader_done         (loader_done),
      .bytes_loaded        (bytes_loaded),
      .checksum            (checksum)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic pushWrite(input int addr, input logic [7:0] data);
      wr_t e;
      e.addr = ADDR_W'(addr);
      e.data = data;
      exp_q.push_back(e);
   endtask

   function automatic logic [7:0] patByte(input int a);
      return 8'((a * 7 + 3) ^ (a >> 8));
   endfunction

   // One full 4-phase transfer; each handshake wait is bounded.
   task automatic applyStimulus(input logic [31:0] word);
      int k;
      @(posedge clk); #1;
      host_bootdata     = word;
      host_bootdata_req = 1'b1;
      k = 0;
      while (host_bootdata_ack !== 1'b1 && k < 200) begin
         @(negedge clk);
         k++;
      end
      checkOutput("ack_rise", 32'(host_bootdata_ack), 32'd1);
      @(posedge clk); #1;
      host_bootdata_req = 1'b0;
      k = 0;
      while (host_bootdata_ack !== 1'b0 && k < 200) begin
         @(negedge clk);
         k++;
      end
      checkOutput("ack_fall", 32'(host_bootdata_ack), 32'd0);
   endtask

   task automatic waitDone(input string name);
      int k;
      k = 0;
      while (loader_done !== 1'b1 && k < 20000) begin
         @(negedge clk);
         k++;
      end
      checkOutput(name, 32'(loader_done), 32'd1);
   endtask

   task automatic waitRun(input string name);
      int k;
      k = 0;
      while (vp_rst_n !== 1'b1 && k < 200) begin
         @(negedge clk);
         k++;
      end
      checkOutput(name, 32'(vp_rst_n), 32'd1);
   endtask

   task automatic restartPulse();
      @(posedge clk); #1;
      host_bootdata_reset = 1'b1;
      @(posedge clk); #1;
      host_bootdata_reset = 1'b0;
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_ack"},      32'(host_bootdata_ack), 32'd0);
      checkOutput({tag, "_we_n"},     32'(sram_we_n),         32'd1);
      checkOutput({tag, "_addr"},     32'(sram_addr),         32'd0);
      checkOutput({tag, "_done"},     32'(loader_done),       32'd0);
      checkOutput({tag, "_bytes"},    32'(bytes_loaded),      32'd0);
      checkOutput({tag, "_checksum"}, 32'(checksum),          32'd0);
      checkOutput({tag, "_vp_rst_n"}, 32'(vp_rst_n),          32'd0);
      checkOutput({tag, "_vp_data"},  32'(vp_data),           32'hFF);
   endtask

   // Monitor: every write cycle must match the head of the expected queue.
   always @(negedge clk) begin
      if (sram_we_n === 1'b0) begin
         mem[sram_addr] = sram_data;
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                     sram_addr, sram_data);
         end else begin
            mon_e = exp_q.pop_front();
            checkOutput("sram_write", {5'b0, sram_addr, sram_data}, {5'b0, mon_e.addr, mon_e.data});
         end
      end
   end

   initial begin
      #3_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset               = 1'b1;
      host_bootdata_reset = 1'b0;
      host_bootdata_req   = 1'b0;
      host_bootdata       = '0;
      host_bootdata_size  = '0;
      vp_addr             = '0;
      vp_en_n             = 1'b1;
      repeat (3) @(negedge clk);
      checkResetValues("reset");
      @(posedge clk); #2;
      reset = 1'b0;

      // Handshake: req held for ten cycles, no writes until it falls.
      $display("[TB] six-byte load with held request");
      @(posedge clk); #1;
      host_bootdata_size = 16'h0006;
      host_bootdata      = 32'h11223344;
      host_bootdata_req  = 1'b1;
      pushWrite(0, 8'h11);
      pushWrite(1, 8'h22);
      pushWrite(2, 8'h33);
      pushWrite(3, 8'h44);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checkOutput("hs_ack_held", 32'(host_bootdata_ack), (i > 0) ? 32'd1 : 32'd0);
         checkOutput("hs_no_early_write", 32'(sram_we_n), 32'd1);
      end
      @(posedge clk); #1;
      host_bootdata_req  = 1'b0;
      host_bootdata_size = 16'h0010;
      @(negedge clk);
      checkOutput("hs_ack_before_edge", 32'(host_bootdata_ack), 32'd1);
      @(negedge clk);
      checkOutput("hs_ack_fall", 32'(host_bootdata_ack), 32'd0);
      checkOutput("hs_first_write", 32'(sram_we_n), 32'd0);

      pushWrite(4, 8'h55);
      pushWrite(5, 8'h66);
      applyStimulus(32'h5566AABB);
      waitDone("t1_done");
      checkOutput("t1_bytes", 32'(bytes_loaded), 32'd6);
      n = 0;
      while (vp_rst_n !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      checkOutput("t1_rst_hold_len", 32'(n), 32'(RST_HOLD));
      checkOutput("t1_all_written", 32'(exp_q.size()), 32'd0);

      $display("[TB] extra word after completion");
      applyStimulus(32'hDEADBEEF);
      repeat (4) @(negedge clk);
      checkOutput("extra_bytes", 32'(bytes_loaded), 32'd6);
      checkOutput("extra_done", 32'(loader_done), 32'd1);
      checkOutput("extra_vp_rst_n", 32'(vp_rst_n), 32'd1);

      $display("[TB] checksum load and async reset during hold");
      restartPulse();
      @(negedge clk);
      checkOutput("restart_bytes", 32'(bytes_loaded), 32'd0);
      checkOutput("restart_vp_rst_n", 32'(vp_rst_n), 32'd0);
      host_bootdata_size = 16'h0003;
      pushWrite(0, 8'h01);
      pushWrite(1, 8'hFF);
      pushWrite(2, 8'hFF);
      applyStimulus(32'h01FFFF00);
      waitDone("cs_done");
      checkOutput("cs_bytes", 32'(bytes_loaded), 32'd3);
      checkOutput("cs_checksum", 32'(checksum), 32'(EXP_SUM));
      repeat (3) @(negedge clk);
      checkOutput("hold_vp_rst_n", 32'(vp_rst_n), 32'd0);
      #2 reset = 1'b1;
      #1 checkResetValues("async");
      repeat (RST_HOLD + 2) @(negedge clk);
      checkOutput("async_vp_rst_n_held", 32'(vp_rst_n), 32'd0);
      @(posedge clk); #2;
      reset = 1'b0;

      $display("[TB] restart during third word");
      host_bootdata_size = 16'h0100;
      pushWrite(0, 8'hA0); pushWrite(1, 8'hA1); pushWrite(2, 8'hA2); pushWrite(3, 8'hA3);
      applyStimulus(32'hA0A1A2A3);
      pushWrite(4, 8'hB0); pushWrite(5, 8'hB1); pushWrite(6, 8'hB2); pushWrite(7, 8'hB3);
      applyStimulus(32'hB0B1B2B3);
      pushWrite(8, 8'hC0); pushWrite(9, 8'hC1); pushWrite(10, 8'hC2);
      applyStimulus(32'hC0C1C2C3);
      n = 0;
      while (!(sram_we_n === 1'b0 && sram_addr == 19'd10) && n < 100) begin
         @(negedge clk);
         n++;
      end
      checkOutput("mid_byte2_addr", 32'(sram_addr), 32'd10);
      host_bootdata_reset = 1'b1;
      @(posedge clk); #1;
      checkOutput("mid_we_n", 32'(sram_we_n), 32'd1);
      checkOutput("mid_bytes", 32'(bytes_loaded), 32'd0);
      checkOutput("mid_done", 32'(loader_done), 32'd0);
      checkOutput("mid_vp_rst_n", 32'(vp_rst_n), 32'd0);
      checkOutput("mid_addr", 32'(sram_addr), 32'd0);
      host_bootdata_reset = 1'b0;
      checkOutput("mid_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("[TB] 2048-byte load and cartridge mapping");
      host_bootdata_size = 16'h0800;
      for (int w = 0; w < 512; w++) begin
         for (int b = 0; b < 4; b++) begin
            pat = patByte(4 * w + b);
            big_word[31 - 8*b -: 8] = pat;
            pushWrite(4 * w + b, pat);
         end
         applyStimulus(big_word);
      end
      waitDone("big_done");
      checkOutput("big_bytes", 32'(bytes_loaded), 32'h800);
      waitRun("big_run");
      checkOutput("big_queue_empty", 32'(exp_q.size()), 32'd0);

      vp_addr = 13'h1805;
      vp_en_n = 1'b0;
      @(negedge clk);
      checkOutput("map_1805_addr", 32'(sram_addr), 32'h00005);
      checkOutput("map_1805_data", 32'(vp_data), 32'h26);
      vp_en_n = 1'b1;
      @(negedge clk);
      checkOutput("map_disabled_data", 32'(vp_data), 32'hFF);
      vp_addr = 13'h07FF;
      vp_en_n = 1'b0;
      @(negedge clk);
      checkOutput("map_07ff_addr", 32'(sram_addr), 32'h007FF);
      checkOutput("map_07ff_data", 32'(vp_data), 32'hFB);
      vp_addr = 13'h0800;
      @(negedge clk);
      checkOutput("map_0800_addr", 32'(sram_addr), 32'h00000);
      checkOutput("map_0800_data", 32'(vp_data), 32'h03);
      vp_en_n = 1'b1;

      repeat (4) @(negedge clk);
      checkOutput("final_queue_empty", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/cart_rom_loader.md
Name: cart_rom_loader

Overview:
Parametrised successor to the single-cart SRAM loader.
- Accepts HOST_W-bit boot words from the control module over a 4-phase req/ack handshake.
- Unpacks each word MSB-byte-first into external SRAM writes, with configurable write recovery and exact byte-count termination.
- After loading, maps console cartridge reads onto SRAM with a size-derived address mask.
- Holds the console in reset for a programmable time after load completes.

Parameters:
- HOST_W, 32, host word width; must be a multiple of 8, range 8..64.
- ADDR_W, 19, SRAM address width.
- VP_ADDR_W, 13, console cartridge address width; must be <= ADDR_W.
- SIZE_W, 16, width of the ROM byte count.
- WAIT_CYC, 1, idle cycles with we_n high between consecutive byte writes; range 1..15.
- RST_HOLD, 8, cycles vp_rst_n stays low after the last byte is written; range 1..255.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: asynchronous, active-high reset.
- host_bootdata_reset, in, 1: synchronous restart of a load, active-high.
- host_bootdata, in, HOST_W: boot word.
- host_bootdata_req, in, 1: word valid request.
- host_bootdata_ack, out, 1: word accepted.
- host_bootdata_size, in, SIZE_W: ROM length in bytes.
- sram_addr, out, ADDR_W: SRAM address.
- sram_data, inout, 8: SRAM data bus; driven only during write.
- sram_we_n, out, 1: SRAM write enable, active-low.
- vp_addr, in, VP_ADDR_W: console cartridge address.
- vp_en_n, in, 1: console cartridge read enable, active-low.
- vp_data, out, 8: cartridge read data.
- vp_rst_n, out, 1: console reset, active-low.
- loader_done, out, 1: load complete.
- bytes_loaded, out, SIZE_W: count of bytes written.
- checksum, out, 16: running byte sum (see Optional Feature).

Behaviour:
- Reset values (reset or host_bootdata_reset):
  - host_bootdata_ack=0, sram_we_n=1, sram_data=Z, sram_addr=0.
  - loader_done=0, bytes_loaded=0, checksum=0, vp_rst_n=0.
  - FSM in IDLE.
  - reset is asynchronous; host_bootdata_reset is sampled on clk.
- Size latch: size_q is captured from host_bootdata_size on the first accepted word of a load. Later changes to the input are ignored until the next restart.
- size_q==0: loader_done asserts on the first IDLE cycle with no writes; the hold counter then starts.
- FSM states: IDLE, ACK, WRITE, RECOVER, HOLD, RUN.
  - IDLE:
    - On req=1 and done=0: latch the word, set ack=1, go to ACK.
    - On req=1 and done=1: set ack=1, discard the word, go to ACK; no writes occur.
  - ACK: ack stays 1 until req=0. Then ack=0 and the state goes to WRITE with byte index 0, or back to IDLE if the word was discarded.
  - WRITE: one cycle.
    - sram_we_n=0, sram_addr=bytes_loaded[ADDR_W-1:0].
    - Data is word byte (HOST_W/8-1-idx), so the MSB byte goes first.
  - RECOVER: WAIT_CYC cycles with we_n=1, then bytes_loaded+1.
    - If bytes_loaded==size_q: loader_done=1, remaining bytes of the word are discarded, go to HOLD.
    - Else if the last byte of the word was written: go to IDLE.
    - Else: idx+1, go to WRITE.
  - HOLD: count RST_HOLD cycles with vp_rst_n=0, then go to RUN.
  - RUN: vp_rst_n=1. Further req words are acked and discarded.
- Address map, RUN only:
  - sram_addr = zero-extended (vp_addr AND mask).
  - mask = (2^ceil(log2(size_q)))-1, saturated to all ones of VP_ADDR_W.
  - Example: size 0x0800 gives mask 0x07FF; 0x0801..0x1000 gives 0x0FFF.
  - Outside RUN, sram_addr follows the loader.
- vp_data = sram_data when in RUN and vp_en_n=0, else 8'hFF. Combinational.
- Arithmetic: bytes_loaded saturates at 2^SIZE_W-1. Address bits above ADDR_W are dropped, so writes wrap modulo 2^ADDR_W.
- Restart mid-word via host_bootdata_reset: abort immediately; we_n=1 and the bus goes Z in the same edge.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- When defined: checksum is the mod-2^16 sum of every byte written, updated in RECOVER. It is cleared on reset and on restart.
- When undefined: checksum is tied to 16'h0000 and no adder is synthesised.

Decomposition:
- Shared package loader_pkg holds:
  - the state enum;
  - the BYTES_PER_WORD constant function (HOST_W/8);
  - the size_to_mask function (size, width) returning the power-of-two mask.
- One sub-module, loader_addr_map: combinational size_q/vp_addr-to-sram_addr mapping plus vp_data gating. It is unit-testable on its own.

Test Plan:
- size=0x0006, words 0x11223344 then 0x5566AABB:
  - SRAM writes [0..5] = 11 22 33 44 55 66;
  - AA and BB are not written;
  - loader_done=1, bytes_loaded=6;
  - vp_rst_n rises exactly RST_HOLD cycles after the last write.
- Handshake: req held high for 10 cycles → ack stays 1 throughout; no write occurs until req falls; ack falls the cycle after req=0.
- size=0x0800, load 2048 bytes, RUN, vp_addr=0x1805 with vp_en_n=0 → sram_addr=0x00005, vp_data equals SRAM[5]; with vp_en_n=1 → vp_data=0xFF.
- host_bootdata_reset asserted during the WRITE of byte 2 of word 3 → the next edge gives we_n=1, bytes_loaded=0, loader_done=0, vp_rst_n=0; a fresh load then restarts at address 0.
- Extra word after done → acked, no sram_we_n pulse, bytes_loaded unchanged; async reset mid-HOLD → vp_rst_n stays 0 and all outputs return to reset values without waiting for clk.
- With LOADER_CHECKSUM_EN, bytes 01 FF FF → checksum=0x01FF; without the macro → checksum=0x0000.
